// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, all in
// the wr_clk domain. One requester owns the port at a time; its valid beats are
// forwarded to the FIFO while the FIFO is not full. When a grant ends, a new owner
// is chosen in the same cycle, so back-to-back grants have no idle bubble.
//
// Build option: define WR_ARB_BURST_EN to let an owner keep the port for up to
// MAX_BURST beats. Without it, every grant is exactly one beat long.
//
// Ports:
//   wr_clk          write-domain clock, rising edge
//   reset_n         asynchronous active-low reset
//   i_req_valid     per-requester beat valid
//   i_req_data      per-requester beats, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready     per-requester beat accepted this cycle
//   i_fifo_full     FIFO full flag
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_data_in  FIFO write data (0 while idle)
//   o_grant_id      index of the current owner
//   o_busy          a grant is active
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
    output logic [ID_WIDTH-1:0]           o_grant_id,
    output logic                          o_busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..16");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_owner;
    logic [ID_WIDTH-1:0]   w_owner_nxt;
    logic [ID_WIDTH-1:0]   r_last;
    logic [ID_WIDTH-1:0]   w_last_nxt;

    logic                  w_any_valid;
    logic                  w_owner_valid;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic [ID_WIDTH-1:0]   w_arb_base;
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_found;
    logic                  w_xfer;
    logic                  w_grant_end;
    logic                  w_burst_done;

    assign w_any_valid   = |i_req_valid;
    assign w_owner_valid = i_req_valid[r_owner];
    assign w_owner_data  = i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];

    // Re-arbitration at grant end rotates from the outgoing owner, which is the
    // last_id value being written this same cycle.
    assign w_arb_base = (r_state == StGrant) ? r_owner : r_last;

    // Round-robin pick: first valid requester after w_arb_base, wrapping around.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req_valid[(int'(w_arb_base) + k) % NUM_REQ]) begin
                w_winner = ID_WIDTH'((int'(w_arb_base) + k) % NUM_REQ);
                w_found  = 1'b1;
            end
        end
    end

`ifdef WR_ARB_BURST_EN
    localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);

    logic [CntWidth-1:0] r_beat_cnt;
    logic [CntWidth-1:0] w_beat_cnt_nxt;

    // The transfer in flight is the one that completes the burst.
    assign w_burst_done = (r_beat_cnt == CntWidth'(MAX_BURST - 1));

    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        if (w_grant_end) begin
            w_beat_cnt_nxt = '0;
        end else if (w_xfer) begin
            w_beat_cnt_nxt = r_beat_cnt + CntWidth'(1);
        end
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
`else
    // Single-beat grants: every transfer ends the grant.
    assign w_burst_done = 1'b1;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_xfer         = 1'b0;
        w_grant_end    = 1'b0;
        o_fifo_wr_en   = 1'b0;
        o_req_ready    = '0;
        o_fifo_data_in = '0;

        unique case (r_state)
            StIdle: begin
                if (w_any_valid) begin
                    w_owner_nxt = w_winner;
                    w_state_nxt = StGrant;
                end
            end
            StGrant: begin
                // A full FIFO simply stalls the owner; the grant is kept.
                w_xfer               = w_owner_valid & ~i_fifo_full;
                o_fifo_wr_en         = w_xfer;
                o_req_ready[r_owner] = w_xfer;
                o_fifo_data_in       = w_owner_data;
                w_grant_end          = (w_xfer & w_burst_done) | ~w_owner_valid;
                if (w_grant_end) begin
                    w_last_nxt = r_owner;
                    if (w_any_valid) begin
                        w_owner_nxt = w_winner;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_last  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign o_grant_id = r_owner;
    assign o_busy     = (r_state == StGrant);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: randomized requesters and FIFO-full stalls,
// compared every cycle against a transaction-level reference model of the arbiter.
// Works with or without WR_ARB_BURST_EN defined.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int MB  = 4;
    localparam int IDW = 2;
`ifdef WR_ARB_BURST_EN
    localparam int BURST = MB;
`else
    localparam int BURST = 1;
`endif

    logic            wr_clk  = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic [IDW-1:0]  grant_id;
    logic            busy;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB),
        .ID_WIDTH  (IDW)
    ) u_dut (
        .wr_clk        (wr_clk),
        .reset_n       (reset_n),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .i_fifo_full   (fifo_full),
        .o_fifo_wr_en  (fifo_wr_en),
        .o_fifo_data_in(fifo_data_in),
        .o_grant_id    (grant_id),
        .o_busy        (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: is someone granted, who, who was last served, beats so far.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_beats;

    // Requester/FIFO stimulus state and knobs.
    bit            s_v[N];
    logic [DW-1:0] s_d[N];
    bit            s_full;
    logic [N-1:0]  en_mask;
    int            p_raise;
    int            p_keep;
    int            p_full;
    bit            rnd_data;

    function automatic int rr_pick(input int base);
        for (int k = 1; k <= N; k++) begin
            if (s_v[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = s_v[k];
            req_data[k*DW +: DW]  = s_d[k];
        end
        fifo_full = s_full;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_wr_en"}, {31'd0, fifo_wr_en}, 32'd0);
        check_val({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
        check_val({tag, "_data"}, {28'd0, fifo_data_in}, 32'd0);
        check_val({tag, "_grant"}, {30'd0, grant_id}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // One clock: compare at negedge, advance model, change inputs just after posedge.
    task automatic do_cycle();
        logic [N-1:0]  e_ready;
        logic [DW-1:0] e_data;
        bit            xfer;
        int            p;
        @(negedge wr_clk);
        e_ready = '0;
        e_data  = '0;
        xfer    = 1'b0;
        if (m_busy) begin
            xfer = s_v[m_owner] && !s_full;
            if (xfer) e_ready[m_owner] = 1'b1;
            e_data = s_d[m_owner];
        end
        check_val("wr_en", {31'd0, fifo_wr_en}, {31'd0, xfer});
        check_val("ready", {28'd0, req_ready}, {28'd0, e_ready});
        check_val("data", {28'd0, fifo_data_in}, {28'd0, e_data});
        check_val("grant_id", {30'd0, grant_id}, m_owner);
        check_val("busy", {31'd0, busy}, {31'd0, m_busy});

        if (!m_busy) begin
            p = rr_pick(m_last);
            if (p >= 0) begin
                m_owner = p;
                m_busy  = 1'b1;
            end
        end else begin
            if (xfer) m_beats++;
            if ((xfer && m_beats == BURST) || !s_v[m_owner]) begin
                m_last  = m_owner;
                m_beats = 0;
                p = rr_pick(m_last);
                if (p >= 0) m_owner = p;
                else m_busy = 1'b0;
            end
        end

        for (int k = 0; k < N; k++) begin
            if (e_ready[k]) begin
                if (rnd_data) s_d[k] = DW'($urandom);
                s_v[k] = en_mask[k] && ($urandom_range(99) < p_keep);
            end else if (!s_v[k]) begin
                s_v[k] = en_mask[k] && ($urandom_range(99) < p_raise);
            end
        end
        s_full = ($urandom_range(99) < p_full);

        @(posedge wr_clk);
        #1;
        drive_inputs();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) do_cycle();
    endtask

    task automatic set_knobs(input logic [N-1:0] mask, input int raise, input int keep,
                             input int full, input bit rnd);
        en_mask  = mask;
        p_raise  = raise;
        p_keep   = keep;
        p_full   = full;
        rnd_data = rnd;
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately.
    task automatic pulse_reset(input int cycles);
        @(negedge wr_clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        repeat (cycles) @(posedge wr_clk);
        #1;
        check_all_zero("rst_hold");
        @(posedge wr_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            s_v[k] = 1'b0;
            s_d[k] = '0;
        end
        s_full = 1'b0;
        set_knobs('0, 0, 0, 0, 1'b0);
        drive_inputs();
        model_reset();

        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("por");
        repeat (3) @(posedge wr_clk);
        #1;
        reset_n = 1'b1;

        // Nobody requesting.
        run(10);

        // Requester 2 alone with constant data 0xA.
        s_v[2] = 1'b1;
        s_d[2] = 4'hA;
        set_knobs(4'b0100, 100, 100, 0, 1'b0);
        drive_inputs();
        run(12);

        // All four requesters continuously valid.
        for (int k = 0; k < N; k++) begin
            s_v[k] = 1'b1;
            s_d[k] = DW'(k + 1);
        end
        set_knobs(4'b1111, 100, 100, 0, 1'b0);
        drive_inputs();
        run(20);

        // Continuous requests with FIFO-full stalls.
        set_knobs(4'b1111, 100, 100, 35, 1'b1);
        run(60);

        // Random valid drops and re-raises.
        set_knobs(4'b1111, 40, 50, 20, 1'b1);
        run(300);

        // Reset in the middle of traffic, then everyone valid.
        set_knobs(4'b1111, 100, 100, 0, 1'b1);
        run(6);
        for (int k = 0; k < N; k++) s_v[k] = 1'b1;
        pulse_reset(2);
        drive_inputs();
        run(20);

        // Sparse traffic, frequent idles.
        set_knobs(4'b1111, 10, 30, 15, 1'b1);
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
